// File: rtl/part_2_put_sched.sv
// Put scheduler: freezes mission clocks on a rising edge and issues one put per arrived clock.
// Build with PUT_SCHED_WDOG_EN to enable the backpressure watchdog and sticky err_o.
module part_2_put_sched #(
  parameter int NUM_CLOCKS     = 4,
  parameter int DATA_W         = 9,
  parameter int FREEZE_STRETCH = 2,
  parameter int WDOG_CYCLES    = 256,
  localparam int IW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CLOCKS-1:0]        mclk_i,
  input  logic [NUM_CLOCKS*DATA_W-1:0] data_i,
  output logic [NUM_CLOCKS-1:0]        freeze_clk_o,
  output logic                         put_valid_o,
  input  logic                         put_ready_i,
  output logic [IW-1:0]                put_idx_o,
  output logic [DATA_W-1:0]            put_data_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int CW = $clog2(NUM_CLOCKS + 1);
  localparam int SW = (FREEZE_STRETCH > 0) ? $clog2(FREEZE_STRETCH + 1) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_STRETCH = 2'd3;

  logic [1:0]            state;
  logic [NUM_CLOCKS-1:0] mclk_d;
  logic [NUM_CLOCKS-1:0] pend;
  logic [NUM_CLOCKS-1:0] rise;
  logic [DATA_W-1:0]     snap [NUM_CLOCKS];
  logic [IW-1:0]         pool [NUM_CLOCKS];
  logic [IW-1:0]         pk_pool [NUM_CLOCKS];
  logic [CW-1:0]         pk_cnt;
  logic [CW-1:0]         w_cnt;
  logic [CW-1:0]         r_cnt;
  logic [SW-1:0]         s_cnt;
  logic                  freeze;
  logic                  valid;
  logic [IW-1:0]         cur_idx;
  logic                  hs;
  logic                  adv;
  logic                  last;

  assign rise         = mclk_i & ~mclk_d;
  assign freeze_clk_o = {NUM_CLOCKS{freeze}};
  assign put_valid_o  = valid;
  assign busy_o       = (state != S_IDLE);
  assign cur_idx      = pool[r_cnt[IW-1:0]];
  assign put_idx_o    = valid ? cur_idx : '0;
  assign put_data_o   = valid ? snap[cur_idx] : '0;
  assign hs           = valid & put_ready_i;
  assign last         = (r_cnt == w_cnt - CW'(1));

`ifdef PUT_SCHED_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd;
  logic          drop;
  logic          err_q;

  assign drop  = valid & ~put_ready_i & (wd == WW'(WDOG_CYCLES - 1));
  assign adv   = hs | drop;
  assign err_o = err_q;

  // Count stalled cycles of the current entry; a timeout drops it and latches err.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else if (state == S_ISSUE && valid && !put_ready_i) begin
      if (drop) begin
        wd    <= '0;
        err_q <= 1'b1;
      end else begin
        wd <= wd + WW'(1);
      end
    end else begin
      wd <= '0;
    end
  end
`else
  assign adv   = hs;
  assign err_o = 1'b0;
`endif

  // Compact the pending mask into an ascending list of channel indices.
  always_comb begin
    pk_cnt = '0;
    for (int k = 0; k < NUM_CLOCKS; k++) pk_pool[k] = '0;
    for (int k = 0; k < NUM_CLOCKS; k++) begin
      if (pend[k]) begin
        pk_pool[pk_cnt[IW-1:0]] = IW'(k);
        pk_cnt = pk_cnt + CW'(1);
      end
    end
  end

  // Track mission clock levels only while unfrozen, so frozen-time edges surface later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      mclk_d <= '0;
    else if (!freeze)
      mclk_d <= mclk_i;
  end

  // Transaction sequencer: capture, load pool, issue puts, stretch freeze.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      pend   <= '0;
      w_cnt  <= '0;
      r_cnt  <= '0;
      s_cnt  <= '0;
      freeze <= 1'b0;
      valid  <= 1'b0;
      for (int k = 0; k < NUM_CLOCKS; k++) begin
        snap[k] <= '0;
        pool[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (|rise) begin
            pend   <= rise;
            freeze <= 1'b1;
            state  <= S_LOAD;
            for (int k = 0; k < NUM_CLOCKS; k++)
              snap[k] <= data_i[k*DATA_W +: DATA_W];
          end
        end
        S_LOAD: begin
          for (int k = 0; k < NUM_CLOCKS; k++) pool[k] <= pk_pool[k];
          w_cnt <= pk_cnt;
          r_cnt <= '0;
          valid <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (adv) begin
            r_cnt <= r_cnt + CW'(1);
            if (last) begin
              valid <= 1'b0;
              s_cnt <= '0;
              state <= S_STRETCH;
            end
          end
        end
        S_STRETCH: begin
          if (s_cnt == SW'(FREEZE_STRETCH)) begin
            freeze <= 1'b0;
            state  <= S_IDLE;
          end else begin
            s_cnt <= s_cnt + SW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_part_2_put_sched.sv
// Scoreboard bench for part_2_put_sched with a transaction-level reference model.
// Stimulus drives just after posedge; checks and monitor sample on negedge.
module tb_part_2_put_sched;

  localparam int N  = 4;
  localparam int DW = 9;
  localparam int FS = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    mclk = '0;
  logic [N*DW-1:0] data = '0;
  logic            ready = 1'b0;
  logic [N-1:0]    freeze_clk_o;
  logic            put_valid_o;
  logic [IW-1:0]   put_idx_o;
  logic [DW-1:0]   put_data_o;
  logic            busy_o;
  logic            err_o;

  part_2_put_sched #(
    .NUM_CLOCKS(N),
    .DATA_W(DW),
    .FREEZE_STRETCH(FS),
    .WDOG_CYCLES(256)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mclk_i(mclk),
    .data_i(data),
    .freeze_clk_o(freeze_clk_o),
    .put_valid_o(put_valid_o),
    .put_ready_i(ready),
    .put_idx_o(put_idx_o),
    .put_data_o(put_data_o),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int dat;
  } put_t;

  put_t sbq[$];
  int tests = 0;
  int fails = 0;

  bit           m_frz;
  bit           m_vld;
  logic [N-1:0] m_last;
  int           m_left;
  int           m_rel;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frz  = 0;
    m_vld  = 0;
    m_last = '0;
    m_left = 0;
    m_rel  = 0;
    sbq.delete();
  endtask

  // Reference: a transaction opens on any rising level seen while unfrozen,
  // queues its puts in channel order, puts appear two edges later, one per
  // ready cycle, and freeze lifts FS+1 edges after the final put.
  task automatic model_step();
    logic [N-1:0] r;
    put_t p;
    if (!m_frz) begin
      r = mclk & ~m_last;
      m_last = mclk;
      m_vld = 0;
      if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          if (r[k]) begin
            p.idx = k;
            p.dat = int'(data[k*DW +: DW]);
            sbq.push_back(p);
          end
        end
        m_left = $countones(r);
        m_frz = 1;
      end
    end else if (m_left > 0) begin
      if (m_vld && ready) begin
        m_left--;
        if (m_left == 0) m_rel = FS + 1;
      end
      m_vld = (m_left > 0);
    end else begin
      m_rel--;
      if (m_rel == 0) m_frz = 0;
    end
  endtask

  task automatic cyc(logic [N-1:0] mc, logic [N*DW-1:0] d, logic rdy);
    mclk = mc;
    data = d;
    ready = rdy;
    @(negedge clk);
    chk("valid", 64'(put_valid_o), 64'(m_vld));
    chk("freeze", 64'(freeze_clk_o), 64'({N{m_frz}}));
    chk("busy", 64'(busy_o), 64'(m_frz));
    chk("err", 64'(err_o), 64'd0);
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] chd(int k, logic [DW-1:0] v,
                                           logic [N*DW-1:0] base);
    logic [N*DW-1:0] t;
    t = base;
    t[k*DW +: DW] = v;
    return t;
  endfunction

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] t;
    for (int k = 0; k < N; k++) t[k*DW +: DW] = DW'($urandom);
    return t;
  endfunction

  // Monitor: every presented put must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && put_valid_o) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL put_unexpected: got idx %0d data %0h expected none",
                   put_idx_o, put_data_o);
        end else begin
          chk("put_idx", 64'(put_idx_o), 64'(sbq[0].idx));
          chk("put_data", 64'(put_data_o), 64'(sbq[0].dat));
          if (ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [N*DW-1:0] d;
    logic [N-1:0]    mc;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freeze", 64'(freeze_clk_o), 64'd0);
    chk("rst_valid", 64'(put_valid_o), 64'd0);
    chk("rst_idx", 64'(put_idx_o), 64'd0);
    chk("rst_data", 64'(put_data_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cyc('0, '0, 1'b1);

    d = chd(2, 9'h133, '0);
    repeat (10) cyc(4'b0100, d, 1'b1);

    d = chd(3, 9'h0FF, chd(0, 9'h1AA, '0));
    repeat (12) cyc(4'b1001, d, 1'b1);

    d = chd(1, 9'h155, '0);
    repeat (6) cyc(4'b0010, d, 1'b0);
    repeat (10) cyc(4'b0010, d, 1'b1);

    repeat (2) cyc('0, '0, 1'b1);
    d = chd(2, 9'h0C3, chd(0, 9'h101, '0));
    cyc(4'b0100, d, 1'b1);
    repeat (14) cyc(4'b0101, d, 1'b1);

    mc = '0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) mc[k] = ~mc[k];
      cyc(mc, rnd_data(), ($urandom_range(0, 3) != 0));
    end
    repeat (20) cyc(mc, rnd_data(), 1'b1);

    repeat (2) cyc('0, '0, 1'b0);
    d = chd(1, 9'h0AB, chd(0, 9'h1CD, '0));
    repeat (4) cyc(4'b0011, d, 1'b0);
    mclk = '0;
    rst = 1'b1;
    #1;
    chk("mid_rst_freeze", 64'(freeze_clk_o), 64'd0);
    chk("mid_rst_valid", 64'(put_valid_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_idx", 64'(put_idx_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) cyc('0, d, 1'b1);
    repeat (10) cyc(4'b0010, d, 1'b1);

`ifndef PUT_SCHED_WDOG_EN
    cyc('0, '0, 1'b0);
    d = chd(3, 9'h07E, '0);
    repeat (300) cyc(4'b1000, d, 1'b0);
    repeat (10) cyc(4'b1000, d, 1'b1);
`endif

    repeat (10) cyc('0, '0, 1'b1);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/part_2_put_sched.md
Name: part_2_put_sched

Overview:
Upstream put scheduler for a partition target interface. It watches the mission clocks in the utility clock domain and detects rising edges. It freezes all mission clocks, snapshots the per-clock data words, and issues one put transaction per arrived clock, in ascending clock index, over a valid/ready handshake to the fringe put stage. Once the pool drains and a stretch interval elapses, it releases the freeze.

Parameters:
NUM_CLOCKS, 4, number of mission clocks / data channels
DATA_W, 9, width of each channel data word ({valid, data[7:0]})
FREEZE_STRETCH, 2, utility cycles freeze is held after last handshake
WDOG_CYCLES, 256, backpressure timeout; used only with optional feature

Ports:
clk_i  in  1  utility clock; all logic on posedge
rst_i  in  1  asynchronous, active-high reset
mclk_i  in  NUM_CLOCKS  mission clock levels, synchronous to clk_i
data_i  in  NUM_CLOCKS*DATA_W  per-channel data; channel k at [k*DATA_W +: DATA_W]
freeze_clk_o  out  NUM_CLOCKS  freeze request to clock gating, all bits equal
put_valid_o  out  1  put request valid
put_ready_i  in  1  put stage accepts current request
put_idx_o  out  $clog2(NUM_CLOCKS)  clock/channel index of current put
put_data_o  out  DATA_W  snapshotted data of current put
busy_o  out  1  state != IDLE
err_o  out  1  sticky watchdog error; tied 0 without feature

Behaviour:
- Reset values: freeze_clk_o=0, put_valid_o=0, put_idx_o=0, put_data_o=0, busy_o=0, err_o=0, state=IDLE, mclk_d=0, r_cnt=w_cnt=0, stretch counter=0.
- Edge detect: mclk_d <= mclk_i only while freeze_clk_o==0. rise = mclk_i & ~mclk_d, evaluated only in IDLE.
- An edge that occurs while frozen is seen at the first IDLE cycle after release, because mclk_d is stale. It is never lost.
- States: IDLE, LOAD, ISSUE, STRETCH.
- IDLE, rise!=0 at edge N:
  - pend <= rise
  - snapshot data_i for all channels
  - freeze_clk_o <= all ones (visible after edge N)
  - go LOAD
- LOAD, one cycle:
  - pool[0..w_cnt-1] <= indices of set pend bits, ascending
  - w_cnt <= popcount(pend); r_cnt <= 0
  - go ISSUE
- ISSUE:
  - put_valid_o=1 from the cycle after LOAD (edge N+2); put_idx_o=pool[r_cnt]; put_data_o=snapshot[pool[r_cnt]].
  - Handshake = put_valid_o & put_ready_i at a posedge. On handshake r_cnt++.
  - After handshake of entry w_cnt-1: put_valid_o <= 0, go STRETCH.
  - Valid, index and data stay stable until handshake; valid never drops without handshake (except reset or watchdog).
  - Back-to-back puts allowed: ready held high gives one put per cycle.
- STRETCH: count FREEZE_STRETCH cycles (0 means one cycle), then freeze_clk_o <= 0 and go IDLE. The IDLE cycle after release may immediately start a new transaction.
- Simultaneous edges on several channels are one transaction with multiple puts, order 0..NUM_CLOCKS-1.
- Pool depth equals NUM_CLOCKS, so overflow is impossible. w_cnt>=1 is guaranteed in LOAD.
- Reset mid-operation: asynchronous return to reset values; freeze released immediately; the partial transaction is discarded and not replayed.
- put_idx_o width: max(1, $clog2(NUM_CLOCKS)).

Optional Feature:
Macro PUT_SCHED_WDOG_EN.
- Defined:
  - A counter runs in ISSUE while put_valid_o & ~put_ready_i, and clears on handshake.
  - Reaching WDOG_CYCLES drops the current entry as if handshaken and sets err_o (sticky until rst_i).
  - A drop on the last entry proceeds to STRETCH.
- Undefined: no counter, err_o tied 0, and ISSUE waits indefinitely.

Test Plan:
- Rise on mclk_i[2] at edge 10 with data ch2=0x133, ready=1 → freeze_clk_o=0xF after edge 10; put_valid_o at edge 12 with idx=2, data=0x133; one handshake; freeze_clk_o=0 after edge 13+FREEZE_STRETCH.
- Simultaneous rise on ch0 (0x1AA) and ch3 (0x0FF), ready=1 → two consecutive puts, idx0/0x1AA then idx3/0x0FF; no put for ch1/ch2.
- Single edge ch1 (0x155), ready low 5 cycles → put_valid_o, idx=1 and data=0x155 stable all 5 cycles; exactly one handshake when ready rises; freeze held until stretch ends.
- mclk_i[0] rises while frozen → no new put during freeze; a new transaction (idx0) starts on the first IDLE cycle after release.
- rst_i asserted in ISSUE with 2 entries pending → all outputs 0 asynchronously; no put_valid_o after deassertion until a fresh edge.
- With PUT_SCHED_WDOG_EN and WDOG_CYCLES=8, ready held low → entry dropped after 8 cycles, err_o=1, freeze released after stretch. Without the macro, same stimulus → valid held, err_o=0.
